exmem_prefetch: RTL and testbench
=================================

EXMEM_PREFETCH -- requirements
Module: exmem_prefetch

Interface
REQ-001 SHALL have parameter LATENCY, default 10, cycles from request acceptance to ack for BRAM accesses (legal 2..32).
REQ-002 SHALL have parameter BURST, default 8, words fetched per read miss and prefetch-buffer entries (power of 2, 2..16).
REQ-003 SHALL have parameter ADDR_W, default 13, BRAM word-index width (depth 2**ADDR_W words).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h3800_0000, byte address of word 0.
REQ-005 SHALL have port wb_clk_i  in  1  the single clock; all state on its rising edge.
REQ-006 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port wb_valid  in  1  request valid, held by the master until ack.
REQ-008 SHALL have port wbs_we_i  in  1  1 write, 0 read.
REQ-009 SHALL have port wbs_sel_i  in  4  byte enables; writes only.
REQ-010 SHALL have port wbs_dat_i  in  32  write data.
REQ-011 SHALL have port wbs_adr_i  in  32  byte address.
REQ-012 SHALL have port wbs_ack_o  out  1  one-cycle completion pulse per request.
REQ-013 SHALL have port wbs_dat_o  out  32  read data, valid with ack, 0 otherwise.

Function
REQ-014 Word index SHALL be ((wbs_adr_i - BASE_ADDR) >> 2) truncated to ADDR_W bits; out-of-range addresses alias modulo depth.
REQ-015 Prefetch buffer SHALL hold BURST entries {valid, ADDR_W-bit index tag, 32-bit data}, direct-mapped by index mod BURST.
REQ-016 States SHALL be IDLE, WREQ, PREF; requests are accepted only in IDLE; wb_valid outside IDLE receives no ack until IDLE returns.
REQ-017 Read hit (IDLE, valid entry, tag equal) SHALL ack combinationally in the same cycle T0 with buffer data; no BRAM access; state stays IDLE.
REQ-018 Read miss accepted at T0 SHALL enter PREF and issue BURST reads to indices i, i+1, ..., i+BURST-1 (mod depth) in cycles T0+1..T0+BURST.
REQ-019 In PREF the first word SHALL be acked at T0+LATENCY; word k (0..BURST-1) SHALL be written into the buffer at T0+LATENCY+k; PREF exits to IDLE the cycle after the last fill.
REQ-020 Write accepted at T0 SHALL enter WREQ, write BRAM with byte enables wbs_sel_i, ack at T0+LATENCY, then return to IDLE.
REQ-021 A write whose index tag-hits a valid buffer entry SHALL byte-merge wbs_dat_i into that entry at acceptance (write-through coherence).
REQ-022 BRAM reads SHALL have one cycle read latency; the delay line SHALL make total latency exactly LATENCY independent of BURST.
REQ-023 wbs_dat_o SHALL be 0 whenever wbs_ack_o is 0; write acks SHALL return 0 data.
REQ-024 Back-to-back: a request presented in the cycle IDLE is re-entered SHALL be accepted that cycle.

Reset
REQ-025 Reset SHALL force state IDLE, clear delay-line valid bits, clear all buffer valid bits, and drive wbs_ack_o=0, wbs_dat_o=0.
REQ-026 Reset mid-PREF or mid-WREQ SHALL abort the operation with no later ack; BRAM contents are not cleared.

Configuration
REQ-027 With EXMEM_PF_STATS_EN defined, SHALL add outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], counting read hits and read misses, saturating at 32'hFFFF_FFFF, reset to 0.
REQ-028 Without EXMEM_PF_STATS_EN those ports and counters SHALL not exist; behaviour is otherwise identical.

Structure
REQ-029 Package exmem_pkg SHALL hold the state encoding, the request record {index, data, sel, we, valid} and the default BASE_ADDR constant.
REQ-030 The fixed-latency request shift register SHALL be sub-module exmem_delay_line (parameters DEPTH, WIDTH); the BRAM is instantiated in exmem_prefetch.

Verification
REQ-031 Reset, read 0x3800_0000 -> miss (no false hit on tag 0), ack at T0+10 with BRAM word 0, buffer filled with words 0..7 by T0+17.
REQ-032 After REQ-031, reads 0x3800_0004..0x3800_001C -> each acked same cycle with correct data, no BRAM enable.
REQ-033 Write 0xDEADBEEF sel=4'b0011 to 0x3800_0008 (cached) -> ack at T0+10; following read acked same cycle with upper half old, lower half 0xBEEF.
REQ-034 Read miss at last word index (2**ADDR_W-1) -> prefetch wraps to indices 0..6; read of BASE_ADDR then hits.
REQ-035 Assert reset at T0+5 of a miss -> no ack ever issued, next read of same address misses.
REQ-036 With EXMEM_PF_STATS_EN, scenario REQ-031+032 -> miss_cnt_o=1, hit_cnt_o=7.

Source files
------------

// File: rtl/exmem_pkg.sv
// ---------------------------------------------------------------------------
// exmem_pkg
// Shared types and constants for the prefetching external-memory bridge:
//   - state_t    : controller state encoding (IDLE / WREQ / PREF)
//   - req_rec_t  : request record carried through the access pipeline
//   - EXMEM_BASE_ADDR_DEFAULT : byte address that maps to BRAM word 0
//   - word_index / byte_merge : address decode and byte-lane merge helpers
// ---------------------------------------------------------------------------
package exmem_pkg;

  localparam logic [31:0] EXMEM_BASE_ADDR_DEFAULT = 32'h3800_0000;

  // The record index field is sized for the widest word index; instances
  // with a narrower BRAM simply use the low ADDR_W bits.
  localparam int unsigned REC_IDX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WREQ = 2'd1,
    PREF = 2'd2
  } state_t;

  typedef struct packed {
    logic [REC_IDX_W-1:0] index;
    logic [31:0]          data;
    logic [3:0]           sel;
    logic                 we;
    logic                 valid;
  } req_rec_t;

  // Word index relative to the base; the caller truncates to ADDR_W bits,
  // which makes out-of-range addresses alias modulo the BRAM depth.
  function automatic logic [31:0] word_index(input logic [31:0] adr,
                                             input logic [31:0] base);
    logic [31:0] off;
    off = adr - base;
    return {2'b00, off[31:2]};
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/exmem_prefetch_if.sv
// ---------------------------------------------------------------------------
// exmem_prefetch_if
// Request/acknowledge bus between a master and the exmem_prefetch bridge.
//   wb_valid   master -> slave  request valid, held until ack
//   wbs_we_i   master -> slave  1 write, 0 read
//   wbs_sel_i  master -> slave  byte enables (writes only)
//   wbs_dat_i  master -> slave  write data
//   wbs_adr_i  master -> slave  byte address
//   wbs_ack_o  slave -> master  one-cycle completion pulse
//   wbs_dat_o  slave -> master  read data, zero when no ack
// ---------------------------------------------------------------------------
interface exmem_prefetch_if;

  logic        wb_valid;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wb_valid, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wb_valid, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/exmem_delay_line.sv
// ---------------------------------------------------------------------------
// exmem_delay_line
// Fixed-latency shift register: a word presented on in_data/in_valid appears
// on out_data/out_valid exactly DEPTH cycles later. DEPTH = 0 is a straight
// wire. Only the valid bits are reset, so an in-flight request is dropped by
// reset; the data stages are plain registers.
// Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   in_valid, in_data    pipeline input
//   out_valid, out_data  pipeline output
// ---------------------------------------------------------------------------
module exmem_delay_line #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = wb_clk_i ^ wb_rst_i;
    assign out_valid      = in_valid;
    assign out_data       = in_data;
  end else begin : g_pipe
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             v_reg;
      logic [WIDTH-1:0] d_reg;
      logic             v_src;
      logic [WIDTH-1:0] d_src;

      if (gi == 0) begin : g_head
        assign v_src = in_valid;
        assign d_src = in_data;
      end else begin : g_link
        assign v_src = g_stage[gi-1].v_reg;
        assign d_src = g_stage[gi-1].d_reg;
      end

      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) v_reg <= 1'b0;
        else          v_reg <= v_src;
      end

      always_ff @(posedge wb_clk_i) begin
        d_reg <= d_src;
      end
    end

    assign out_valid = g_stage[DEPTH-1].v_reg;
    assign out_data  = g_stage[DEPTH-1].d_reg;
  end

endmodule

// File: rtl/exmem_prefetch.sv
// ---------------------------------------------------------------------------
// exmem_prefetch
// Block-RAM backed memory with a BURST-entry direct-mapped prefetch buffer.
//   - Read hit in IDLE: acked combinationally from the buffer, no BRAM access.
//   - Read miss: BURST consecutive BRAM reads are issued; the first word is
//     acked LATENCY cycles after acceptance and all words fill the buffer.
//   - Write: byte-enabled BRAM write, acked LATENCY cycles after acceptance;
//     a buffered copy of the same word is byte-merged at acceptance.
// Access pipeline: issue register -> BRAM (1-cycle read) -> stage 2 register
// -> exmem_delay_line of LATENCY-2 stages, so every access completes exactly
// LATENCY cycles after it is issued, whatever BURST is.
// Ports:
//   wb_clk_i   clock
//   wb_rst_i   asynchronous active-high reset
//   bus        exmem_prefetch_if.slave request/ack bus
//   hit_cnt_o, miss_cnt_o  saturating read hit/miss counters, present only
//              when the EXMEM_PF_STATS_EN macro is defined
// Parameters: LATENCY (2..32), BURST (power of 2, 2..16), ADDR_W, BASE_ADDR.
// ---------------------------------------------------------------------------
module exmem_prefetch
  import exmem_pkg::*;
#(
  parameter int unsigned LATENCY   = 10,
  parameter int unsigned BURST     = 8,
  parameter int unsigned ADDR_W    = 13,
  parameter logic [31:0] BASE_ADDR = EXMEM_BASE_ADDR_DEFAULT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  exmem_prefetch_if.slave   bus
`ifdef EXMEM_PF_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int unsigned SLOT_W = $clog2(BURST);
  localparam logic [SLOT_W:0]   BURST_CNT = (SLOT_W + 1)'(BURST);
  localparam logic [SLOT_W-1:0] LAST_FILL = SLOT_W'(BURST - 1);

  // ---------------- request decode ----------------
  logic [31:0]       req_word;
  logic [ADDR_W-1:0] req_idx;
  logic [SLOT_W-1:0] req_slot;

  assign req_word = word_index(bus.wbs_adr_i, BASE_ADDR);
  assign req_idx  = req_word[ADDR_W-1:0];
  assign req_slot = req_idx[SLOT_W-1:0];

  // ---------------- prefetch buffer ----------------
  logic [BURST-1:0]  buf_valid_reg;
  logic [ADDR_W-1:0] buf_tag_reg  [BURST];
  logic [31:0]       buf_data_reg [BURST];
  logic              hit;

  assign hit = buf_valid_reg[req_slot] && (buf_tag_reg[req_slot] == req_idx);

  // ---------------- controller state ----------------
  state_t            state_reg, state_next;
  req_rec_t          iss_reg, iss_next;
  req_rec_t          s2_reg;
  logic [SLOT_W:0]   issue_cnt_reg, issue_cnt_next;
  logic [SLOT_W-1:0] fill_cnt_reg, fill_cnt_next;

  // ---------------- BRAM ----------------
  logic [31:0]       mem [1 << ADDR_W];
  logic [31:0]       bram_q;
  logic [ADDR_W-1:0] bram_addr;

  assign bram_addr = iss_reg.index[ADDR_W-1:0];

  always_ff @(posedge wb_clk_i) begin
    if (iss_reg.valid) begin
      if (iss_reg.we) begin
        for (int b = 0; b < 4; b++) begin
          if (iss_reg.sel[b]) mem[bram_addr][8*b +: 8] <= iss_reg.data[8*b +: 8];
        end
      end else begin
        bram_q <= mem[bram_addr];
      end
    end
  end

  // ---------------- fixed-latency completion path ----------------
  req_rec_t          dl_in;
  req_rec_t          dl_out;
  logic              dl_out_valid;
  logic [ADDR_W-1:0] fill_idx;
  logic [SLOT_W-1:0] fill_slot;

  // BRAM read data is only meaningful one cycle after the issue, i.e. when
  // the request sits in stage 2; writes carry zero data to their ack.
  always_comb begin
    dl_in      = s2_reg;
    dl_in.data = s2_reg.we ? 32'h0 : bram_q;
  end

  exmem_delay_line #(
    .DEPTH (int'(LATENCY) - 2),
    .WIDTH ($bits(req_rec_t))
  ) u_delay (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .in_valid  (s2_reg.valid),
    .in_data   (dl_in),
    .out_valid (dl_out_valid),
    .out_data  (dl_out)
  );

  assign fill_idx  = dl_out.index[ADDR_W-1:0];
  assign fill_slot = fill_idx[SLOT_W-1:0];

  // ---------------- next-state / outputs ----------------
  logic        ack;
  logic [31:0] ack_dat;
  logic        rd_hit;
  logic        rd_miss;
  logic        merge_en;
  logic        fill_en;

  always_comb begin
    state_next     = state_reg;
    iss_next       = iss_reg;
    iss_next.valid = 1'b0;
    issue_cnt_next = issue_cnt_reg;
    fill_cnt_next  = fill_cnt_reg;
    ack            = 1'b0;
    ack_dat        = 32'h0;
    rd_hit         = 1'b0;
    rd_miss        = 1'b0;
    merge_en       = 1'b0;
    fill_en        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.wb_valid) begin
          if (bus.wbs_we_i) begin
            merge_en   = hit;
            iss_next   = '{index: REC_IDX_W'(req_idx), data: bus.wbs_dat_i,
                           sel: bus.wbs_sel_i, we: 1'b1, valid: 1'b1};
            state_next = WREQ;
          end else if (hit) begin
            rd_hit  = 1'b1;
            ack     = 1'b1;
            ack_dat = buf_data_reg[req_slot];
          end else begin
            rd_miss        = 1'b1;
            iss_next       = '{index: REC_IDX_W'(req_idx), data: 32'h0,
                               sel: 4'h0, we: 1'b0, valid: 1'b1};
            issue_cnt_next = (SLOT_W + 1)'(1);
            fill_cnt_next  = '0;
            state_next     = PREF;
          end
        end
      end

      WREQ: begin
        if (dl_out_valid) begin
          ack        = 1'b1;
          state_next = IDLE;
        end
      end

      PREF: begin
        // Issue side: walk forward one word per cycle, wrapping at depth.
        if (issue_cnt_reg != BURST_CNT) begin
          iss_next.index = REC_IDX_W'(bram_addr + 1'b1);
          iss_next.valid = 1'b1;
          issue_cnt_next = issue_cnt_reg + 1'b1;
        end
        // Completion side: every returning word fills the buffer; only the
        // first one answers the waiting master.
        if (dl_out_valid) begin
          fill_en       = 1'b1;
          fill_cnt_next = fill_cnt_reg + 1'b1;
          if (fill_cnt_reg == '0) begin
            ack     = 1'b1;
            ack_dat = dl_out.data;
          end
          if (fill_cnt_reg == LAST_FILL) state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.wbs_ack_o = ack;
  assign bus.wbs_dat_o = ack_dat;

  // ---------------- state registers ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg     <= IDLE;
      iss_reg       <= '0;
      s2_reg        <= '0;
      issue_cnt_reg <= '0;
      fill_cnt_reg  <= '0;
      buf_valid_reg <= '0;
    end else begin
      state_reg     <= state_next;
      iss_reg       <= iss_next;
      s2_reg        <= iss_reg;
      issue_cnt_reg <= issue_cnt_next;
      fill_cnt_reg  <= fill_cnt_next;
      if (fill_en) buf_valid_reg[fill_slot] <= 1'b1;
    end
  end

  // Tag/data need no reset: an entry is never read while its valid bit is 0.
  always_ff @(posedge wb_clk_i) begin
    if (fill_en) begin
      buf_tag_reg[fill_slot]  <= fill_idx;
      buf_data_reg[fill_slot] <= dl_out.data;
    end else if (merge_en) begin
      buf_data_reg[req_slot] <= byte_merge(buf_data_reg[req_slot],
                                           bus.wbs_dat_i, bus.wbs_sel_i);
    end
  end

  // Record fields that are carried along but not consumed at this point.
  logic unused_bits;
  assign unused_bits = ^{req_word, dl_out};

`ifdef EXMEM_PF_STATS_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (rd_hit && (hit_cnt_reg != 32'hFFFF_FFFF))   hit_cnt_reg  <= hit_cnt_reg + 32'd1;
      if (rd_miss && (miss_cnt_reg != 32'hFFFF_FFFF)) miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_reg;
  assign miss_cnt_o = miss_cnt_reg;
`else
  logic unused_stats;
  assign unused_stats = rd_hit ^ rd_miss;
`endif

endmodule

// File: tb/tb_exmem_prefetch.sv
// ---------------------------------------------------------------------------
// tb_exmem_prefetch
// Directed scoreboard bench for exmem_prefetch (LATENCY=10, BURST=8,
// ADDR_W=13). The driver pushes the expected {data, ack cycle} of each
// request; an independent monitor pops and compares on every ack, and checks
// that read data is zero whenever ack is low. Counter checks are included
// when EXMEM_PF_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_exmem_prefetch;
  import exmem_pkg::*;

  localparam logic [31:0] BASE = EXMEM_BASE_ADDR_DEFAULT;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i;

  exmem_prefetch_if bus ();

`ifdef EXMEM_PF_STATS_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  exmem_prefetch #(
    .LATENCY   (10),
    .BURST     (8),
    .ADDR_W    (13),
    .BASE_ADDR (BASE)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .bus       (bus)
`ifdef EXMEM_PF_STATS_EN
    ,
    .hit_cnt_o (hit_cnt_o),
    .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Preloaded BRAM contents for words 0..7.
  function automatic logic [31:0] word_val(input int k);
    return 32'h1111_1111 * 32'(k + 1);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge wb_clk_i) begin : mon
    exp_t e;
    if (wb_rst_i !== 1'b1) begin
      n_tests++;
      if (bus.wbs_ack_o === 1'b1) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: ack at cycle %0d data %h, required no ack", cyc, bus.wbs_dat_o);
        end else begin
          e = sb.pop_front();
          if (bus.wbs_dat_o !== e.data || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL %s: ack cycle %0d data %h, required cycle %0d data %h",
                     e.name, cyc, bus.wbs_dat_o, e.cyc, e.data);
          end else begin
            $display("[TB] %s: ack cycle %0d data %h ok", e.name, cyc, bus.wbs_dat_o);
          end
        end
      end else if (bus.wbs_dat_o !== 32'h0) begin
        n_fail++;
        $display("FAIL dat_zero_no_ack: cycle %0d data %h, required 00000000", cyc, bus.wbs_dat_o);
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; presents the request in that cycle and
  // holds it until ack. lat is the expected ack cycle relative to that cycle.
  task automatic do_req(input string name, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] wdat,
                        input logic [31:0] exp_dat, input int lat);
    exp_t e;
    bit   got;
    e.data = exp_dat;
    e.cyc  = cyc + lat;
    e.name = name;
    sb.push_back(e);
    bus.wb_valid  = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_dat_i = wdat;
    bus.wbs_adr_i = adr;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge wb_clk_i);
      if (bus.wbs_ack_o === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no ack within 64 cycles, required ack at cycle %0d", name, e.cyc);
      sb.delete();
    end
    @(posedge wb_clk_i);
    #1;
    bus.wb_valid  = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_dat_i = 32'h0;
    bus.wbs_adr_i = 32'h0;
  endtask

  task automatic pulse_reset();
    @(posedge wb_clk_i);
    #1;
    wb_rst_i     = 1'b1;
    bus.wb_valid = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.wb_valid  = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_dat_i = 32'h0;
    bus.wbs_adr_i = 32'h0;
    wb_rst_i      = 1'b1;

    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    n_tests++;
    if (bus.wbs_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack: ack %b, required 0", bus.wbs_ack_o);
    end
    n_tests++;
    if (bus.wbs_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_dat: data %h, required 00000000", bus.wbs_dat_o);
    end
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;

    // Preload BRAM words 0..7 and the last word; writes run back-to-back.
    for (int k = 0; k < 8; k++)
      do_req($sformatf("preload_wr%0d", k), 1'b1, BASE + 32'(4 * k), 4'hF,
             word_val(k), 32'h0, 10);
    do_req("preload_wr_last", 1'b1, BASE + 32'h7FFC, 4'hF, 32'hFEED_F00D, 32'h0, 10);

    // Reset must leave BRAM intact and empty the buffer.
    pulse_reset();

    // Miss on word 0 (tag 0 after reset must not hit).
    do_req("rd0_miss", 1'b0, BASE, 4'h0, 32'h0, word_val(0), 10);
    // Presented while PREF still fills: held off until IDLE returns.
    do_req("rd1_wait_pref", 1'b0, BASE + 32'h4, 4'h0, 32'h0, word_val(1), 7);
    for (int k = 2; k < 8; k++)
      do_req($sformatf("rd%0d_hit", k), 1'b0, BASE + 32'(4 * k), 4'h0, 32'h0, word_val(k), 0);

`ifdef EXMEM_PF_STATS_EN
    n_tests++;
    if (miss_cnt_o !== 32'd1) begin
      n_fail++;
      $display("FAIL miss_cnt: got %0d, required 1", miss_cnt_o);
    end
    n_tests++;
    if (hit_cnt_o !== 32'd7) begin
      n_fail++;
      $display("FAIL hit_cnt: got %0d, required 7", hit_cnt_o);
    end
`endif

    // Partial write to a cached word: buffer merged, BRAM byte-written.
    do_req("wr2_merge", 1'b1, BASE + 32'h8, 4'b0011, 32'hDEAD_BEEF, 32'h0, 10);
    do_req("rd2_merged_buf", 1'b0, BASE + 32'h8, 4'h0, 32'h0, 32'h3333_BEEF, 0);

    // Last word index: prefetch wraps to words 0..6.
    do_req("rd_last_miss", 1'b0, BASE + 32'h7FFC, 4'h0, 32'h0, 32'hFEED_F00D, 10);
    do_req("rd0_wrap_hit", 1'b0, BASE, 4'h0, 32'h0, word_val(0), 7);
    do_req("rd2_merged_bram", 1'b0, BASE + 32'h8, 4'h0, 32'h0, 32'h3333_BEEF, 0);

    // Slot 7 now holds the last word, so word 7 is a conflict miss.
    do_req("rd7_conflict_miss", 1'b0, BASE + 32'h1C, 4'h0, 32'h0, word_val(7), 10);
    repeat (10) @(posedge wb_clk_i);
    #1;

    // Miss aborted by reset at T0+5: no ack may follow (monitor flags any).
    bus.wb_valid  = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = BASE;
    repeat (5) @(posedge wb_clk_i);
    #1;
    wb_rst_i     = 1'b1;
    bus.wb_valid = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    repeat (30) @(posedge wb_clk_i);
    #1;
    do_req("rd0_after_abort_miss", 1'b0, BASE, 4'h0, 32'h0, word_val(0), 10);

    repeat (12) @(posedge wb_clk_i);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
